// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner: channel map, default width,
// repeat FSM states and a small elaboration helper.
package input_cond_pkg;

  localparam int unsigned DEFAULT_NCH = 7;

  localparam int unsigned CH_DIR0     = 0;
  localparam int unsigned CH_DIR1     = 1;
  localparam int unsigned CH_DIR2     = 2;
  localparam int unsigned CH_DIR3     = 3;
  localparam int unsigned CH_BUTTON   = 4;
  localparam int unsigned CH_BADCOLL  = 5;
  localparam int unsigned CH_GOODCOLL = 6;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned channel: synchroniser, debounce, edge pulse and, when built
// with INPUT_COND_AUTOREPEAT_EN, an auto-repeat FSM for held inputs.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 4,
  parameter bit          RISE_EN       = 1'b1,
  parameter bit          FALL_EN       = 1'b0,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic nRst,
  input  logic sig,
  output logic level,
  output logic pulse
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam bit RPT_BUILD = 1'b1;
`else
  localparam bit RPT_BUILD = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   synced;
  logic                   toggle_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   rpt_pulse_c;

  // Synchroniser chain; the last stage feeds the debouncer.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign toggle_c = (synced != level) && (db_cnt == DB_W'(DB_CYCLES - 1));
  assign rise_c   = toggle_c & ~level;
  assign fall_c   = toggle_c & level;

  // Pulse is registered on the same edge as the level change it reports.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      db_cnt <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      if (synced == level) begin
        db_cnt <= '0;
      end else if (toggle_c) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      pulse <= (rise_c & RISE_EN) | (fall_c & FALL_EN) | rpt_pulse_c;
    end
  end

  if (RPT_BUILD && REPEAT_EN && (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0)) begin : g_rpt
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic [RPT_W-1:0] cnt;
    logic [RPT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        state <= RPT_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // A falling level always wins and suppresses any repeat on that edge.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + RPT_W'(1);
      rpt_pulse_c = 1'b0;
      case (state)
        RPT_IDLE: begin
          cnt_nxt = '0;
          if (rise_c) state_nxt = RPT_DELAY;
        end
        RPT_DELAY: begin
          if (cnt == RPT_W'(REPEAT_DELAY - 1)) begin
            rpt_pulse_c = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = RPT_REPEAT;
          end
        end
        RPT_REPEAT: begin
          if (cnt == RPT_W'(REPEAT_PERIOD - 1)) begin
            rpt_pulse_c = 1'b1;
            cnt_nxt     = '0;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = RPT_IDLE;
        end
      endcase
      if (fall_c) begin
        state_nxt   = RPT_IDLE;
        cnt_nxt     = '0;
        rpt_pulse_c = 1'b0;
      end
    end
  end else begin : g_no_rpt
    assign rpt_pulse_c = 1'b0;
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-channel sync/debounce/edge pulses plus
// pulse summary. Auto-repeat is built only with INPUT_COND_AUTOREPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned    NCH           = DEFAULT_NCH,
  parameter int unsigned    SYNC_STAGES   = 2,
  parameter int unsigned    DB_CYCLES     = 4,
  parameter logic [NCH-1:0] RISE_MASK     = '1,
  parameter logic [NCH-1:0] FALL_MASK     = '0,
  parameter logic [NCH-1:0] REPEAT_MASK   = NCH'(4'hF),
  parameter int unsigned    REPEAT_DELAY  = 20,
  parameter int unsigned    REPEAT_PERIOD = 8
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic [NCH-1:0]           sig_i,
  output logic [NCH-1:0]           level_o,
  output logic [NCH-1:0]           pulse_o,
  output logic                     any_pulse_o,
  output logic [$clog2(NCH)-1:0]   pulse_idx_o
);

  localparam int unsigned IDX_W = $clog2(NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .RISE_EN      (RISE_MASK[i]),
      .FALL_EN      (FALL_MASK[i]),
      .REPEAT_EN    (REPEAT_MASK[i] & RISE_MASK[i]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .nRst (nRst),
      .sig  (sig_i[i]),
      .level(level_o[i]),
      .pulse(pulse_o[i])
    );
  end

  assign any_pulse_o = |pulse_o;

  // Lowest set bit wins; scan from the top so lower indices overwrite.
  always_comb begin
    pulse_idx_o = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (pulse_o[i]) pulse_idx_o = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a rise-mask DUT and a fall-only DUT
// share one stimulus; expected pulses are queued by cycle when inputs change.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int LAT = 6;

  typedef struct {
    int         cyc;
    logic [6:0] pa;
    logic [6:0] la;
    logic [6:0] pb;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic [6:0] sig;
  logic [6:0] level_a, pulse_a, level_b, pulse_b;
  logic       any_a, any_b;
  logic [2:0] idx_a, idx_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  input_conditioner u_dut_a (
    .clk(clk), .nRst(nRst), .sig_i(sig), .level_o(level_a), .pulse_o(pulse_a),
    .any_pulse_o(any_a), .pulse_idx_o(idx_a)
  );

  input_conditioner #(
    .RISE_MASK(7'b000_0000), .FALL_MASK(7'b010_0000)
  ) u_dut_b (
    .clk(clk), .nRst(nRst), .sig_i(sig), .level_o(level_b), .pulse_o(pulse_b),
    .any_pulse_o(any_b), .pulse_idx_o(idx_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] bit_of(input int unsigned ch);
    return 7'(1) << ch;
  endfunction

  function automatic logic [2:0] low_idx(input logic [6:0] v);
    logic [2:0] r = '0;
    for (int i = 6; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic push(input int at, input logic [6:0] pa, input logic [6:0] la,
                      input logic [6:0] pb);
    exp_t e;
    e.cyc = at; e.pa = pa; e.la = la; e.pb = pb;
    sb.push_back(e);
  endtask

  task automatic step(input logic [6:0] v);
    @(negedge clk); #1;
    sig = v;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (12) @(negedge clk);
  endtask

  // Compare on the falling edge: scheduled entries are checked in full,
  // any pulse outside a scheduled cycle is an error.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("pulse_a", 32'(pulse_a), 32'(e.pa));
      check("any_a",   32'(any_a),   32'(e.pa != 0));
      check("idx_a",   32'(idx_a),   32'(low_idx(e.pa)));
      check("level_a", 32'(level_a), 32'(e.la));
      check("pulse_b", 32'(pulse_b), 32'(e.pb));
      check("any_b",   32'(any_b),   32'(e.pb != 0));
      check("idx_b",   32'(idx_b),   32'(low_idx(e.pb)));
      check("level_b", 32'(level_b), 32'(e.la));
    end else if ((pulse_a | pulse_b) != 7'd0) begin
      check("spurious_pulse", 32'({pulse_b, pulse_a}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] all_ch;
    int n0;
    all_ch = bit_of(CH_DIR0) | bit_of(CH_DIR1) | bit_of(CH_DIR2) | bit_of(CH_DIR3) |
             bit_of(CH_BUTTON) | bit_of(CH_BADCOLL) | bit_of(CH_GOODCOLL);
    sig  = '0;
    nRst = 1'b0;

    // Held in reset with all inputs high.
    repeat (3) @(negedge clk);
    step(all_ch);
    repeat (3) @(negedge clk);
    #1;
    check("rst_pulse", 32'(pulse_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_any",   32'(any_a),   32'd0);
    check("rst_idx",   32'(idx_a),   32'd0);
    check("rst_pulse_b", 32'(pulse_b), 32'd0);
    @(negedge clk); #1;
    nRst = 1'b1;
    push(cyc + LAT, all_ch, all_ch, 7'd0);
    drain();

    // All fall: only the fall-mask DUT reports channel 5.
    step(7'd0);
    push(cyc + LAT, 7'd0, 7'd0, bit_of(CH_BADCOLL));
    drain();

    // Glitch of 3 cycles is rejected.
    step(bit_of(CH_BUTTON));
    repeat (2) @(negedge clk);
    step(7'd0);
    drain();
    check("glitch_level", 32'(level_a), 32'd0);

    // Held for 4 cycles is accepted once.
    step(bit_of(CH_BUTTON));
    push(cyc + LAT, bit_of(CH_BUTTON), bit_of(CH_BUTTON), 7'd0);
    repeat (3) @(negedge clk);
    step(7'd0);
    drain();
    check("hold4_level_after", 32'(level_a), 32'd0);

    // Channel 5 alone rises then falls.
    step(bit_of(CH_BADCOLL));
    push(cyc + LAT, bit_of(CH_BADCOLL), bit_of(CH_BADCOLL), 7'd0);
    repeat (10) @(negedge clk);
    step(7'd0);
    push(cyc + LAT, 7'd0, 7'd0, bit_of(CH_BADCOLL));
    drain();

    // Simultaneous rise on channels 6 and 2.
    step(bit_of(CH_GOODCOLL) | bit_of(CH_DIR2));
    push(cyc + LAT, 7'b100_0100, 7'b100_0100, 7'd0);
    drain();
    step(7'd0);
    drain();

    // Reset pulsed mid-debounce restarts the full latency.
    step(bit_of(CH_DIR0));
    @(negedge clk);
    @(negedge clk); #1;
    nRst = 1'b0;
    #1;
    check("rst_mid_pulse", 32'(pulse_a), 32'd0);
    check("rst_mid_level", 32'(level_a), 32'd0);
    @(negedge clk); #1;
    nRst = 1'b1;
    push(cyc + LAT, bit_of(CH_DIR0), bit_of(CH_DIR0), 7'd0);
    drain();
    step(7'd0);
    drain();

    // Hold a direction and the button together.
    step(bit_of(CH_DIR1) | bit_of(CH_BUTTON));
    n0 = cyc;
    push(n0 + LAT, 7'b001_0010, 7'b001_0010, 7'd0);
`ifdef INPUT_COND_AUTOREPEAT_EN
    push(n0 + LAT + 20, bit_of(CH_DIR1), 7'b001_0010, 7'd0);
    push(n0 + LAT + 28, bit_of(CH_DIR1), 7'b001_0010, 7'd0);
    push(n0 + LAT + 36, bit_of(CH_DIR1), 7'b001_0010, 7'd0);
`endif
    while (cyc < n0 + 38) @(negedge clk);
    step(7'd0);
    drain();
    check("repeat_level_after", 32'(level_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised multi-channel input conditioner. It is the next generation of the game's edge-pulse stage.
- It takes raw asynchronous game inputs (direction buttons, action button, collision flags), synchronises and debounces them, and emits one-cycle edge pulses.
- Edge polarity is selectable per channel. Held directions can optionally auto-repeat.
- It sits between the top-level pins / collision logic and the snake control FSM.

Parameters:
- NCH, 7: number of channels (>=2).
- SYNC_STAGES, 2: synchroniser flops per channel (>=1).
- DB_CYCLES, 4: consecutive cycles a new synced value must persist before it is accepted (>=1; 1 = no debounce).
- RISE_MASK, {NCH{1'b1}}: bit i set -> channel i pulses on a 0->1 transition of the debounced level.
- FALL_MASK, '0: bit i set -> channel i pulses on a 1->0 transition of the debounced level.
- REPEAT_MASK, 7'b000_1111: channels eligible for auto-repeat (only used with the optional feature).
- REPEAT_DELAY, 20: cycles from the rise pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- sig_i  in  NCH  raw asynchronous inputs.
- level_o  out  NCH  debounced stable level per channel.
- pulse_o  out  NCH  one-cycle pulse per channel.
- any_pulse_o  out  1  OR of pulse_o.
- pulse_idx_o  out  $clog2(NCH)  index of the lowest set bit of pulse_o.

Behaviour:
- Reset and clock: reset nRst, asynchronous, active-low; clock clk.
- Values held in reset: sync flops, level_o, pulse_o, debounce counters and repeat state all 0. any_pulse_o=0, pulse_idx_o=0.
- Synchroniser: sig_i passes through a SYNC_STAGES flop chain; the last stage is synced[i].
- Debounce, per channel:
  - Counter width $clog2(DB_CYCLES+1).
  - If synced != level: counter += 1.
  - When the counter would reach DB_CYCLES, on that edge level toggles and the counter clears.
  - If synced == level: counter clears. Any glitch shorter than DB_CYCLES restarts the count.
- Latency: a change on sig_i first sampled at edge E1 appears on level_o at edge E(SYNC_STAGES+DB_CYCLES). With defaults this is the 6th edge.
- Edge pulse: pulse_o[i] is registered. It is high for exactly the one cycle in which level_o[i] changes:
  - on a rise, if RISE_MASK[i];
  - on a fall, if FALL_MASK[i].
- If both masks are set, the channel pulses on both edges.
- any_pulse_o and pulse_idx_o are combinational from pulse_o. pulse_idx_o=0 when there is no pulse.
- Channels are fully independent. Simultaneous pulses on several channels are all reported on pulse_o; pulse_idx_o reports the lowest index.
- Reset mid-debounce or mid-repeat: all state returns to the reset values immediately. No pulse is produced on reset release unless the input still satisfies the full SYNC+DB latency afterwards.
- An input already high at reset release produces a rise pulse after SYNC_STAGES+DB_CYCLES edges.

Optional Feature:
- Macro: INPUT_COND_AUTOREPEAT_EN.
- Defined: per channel with REPEAT_MASK[i] & RISE_MASK[i] set, a repeat FSM runs with states IDLE, DELAY, REPEAT.
- Transitions:
  - IDLE -> DELAY on the rise pulse, cycle t; the counter clears.
  - DELAY: a pulse at t+REPEAT_DELAY, then -> REPEAT.
  - REPEAT: a pulse every REPEAT_PERIOD cycles.
  - Any state -> IDLE on the edge level_o[i] falls. No repeat pulse is issued on that edge.
- Repeat pulses OR into pulse_o and never coincide with an edge pulse on the same channel.
- Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Undefined: no repeat logic is synthesised; REPEAT_* parameters are ignored; pulses occur on edges only.

Decomposition:
- Package input_cond_pkg:
  - channel index constants CH_DIR0..CH_DIR3=0..3, CH_BUTTON=4, CH_BADCOLL=5, CH_GOODCOLL=6;
  - default NCH=7;
  - repeat FSM state enum rpt_state_t.
- Sub-module input_cond_channel: one channel covering sync, debounce, edge detect and optional repeat. It is instantiated NCH times via generate.
- The top adds the OR and the priority encoder.

Test Plan:
- Reset: hold nRst=0 with sig_i=7'h7F -> all outputs 0. Release -> pulse_o=7'h7F on the 6th edge, for 1 cycle. pulse_idx_o=0, level_o=7'h7F.
- Glitch: sig_i[4] high for 3 cycles, then low -> level_o[4] and pulse_o[4] stay 0. Held for 4 cycles -> pulse_o[4] exactly once, 6 edges after first sample.
- Fall mask: FALL_MASK=7'b010_0000, RISE_MASK=0. Channel 5 rises then falls -> only one pulse, on the level_o[5] 1->0 cycle.
- Simultaneous: sig_i[6] and sig_i[2] rise in the same cycle -> pulse_o=7'b100_0100, pulse_idx_o=2, any_pulse_o=1.
- Reset mid-debounce: sig_i[0] rises; nRst pulses low at edge 3 -> no pulse. After release, pulse_o[0] on the 6th edge.
- Auto-repeat (macro defined): hold sig_i[1] -> pulses at cycles t, t+20, t+28, t+36. Release -> no further pulses. Channel 4 held -> single pulse only.
